lsu2wb_queue: RTL

Parametrised, buffered successor of the LSU-to-writeback router. It accepts LSU load/store responses and steers each one into a scalar (out_x) and/or vector (out_v) writeback queue of configurable depth, so a stalled writeback port no longer back-pressures the LSU directly. Responses carrying no register write are retired immediately. The block sits between the LSU response port and the writeback arbiter inside the SM pipeline.

---
 rtl/lsu2wb_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/lsu2wb_queue.sv
// Buffered LSU-response router. Each response is steered into a scalar (X) queue,
// a vector (V) queue, or both. Responses that write no register are retired at once.
module lsu2wb_queue #(
  parameter int NUM_THREAD = 8,
  parameter int XLEN       = 32,
  parameter int DEPTH_WARP = 3,
  parameter int REG_W      = 8,
  parameter int X_DEPTH    = 2,
  parameter int V_DEPTH    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         lsu_rsp_valid_i,
  output logic                         lsu_rsp_ready_o,
  input  logic [DEPTH_WARP-1:0]        lsu_rsp_warp_id_i,
  input  logic                         lsu_rsp_wxd_i,
  input  logic                         lsu_rsp_wfd_i,
  input  logic [REG_W-1:0]             lsu_rsp_reg_idxw_i,
  input  logic [NUM_THREAD-1:0]        lsu_rsp_mask_i,
  input  logic [XLEN*NUM_THREAD-1:0]   lsu_rsp_data_i,
  output logic                         out_x_valid_o,
  input  logic                         out_x_ready_i,
  output logic [DEPTH_WARP-1:0]        out_x_warp_id_o,
  output logic [REG_W-1:0]             out_x_reg_idxw_o,
  output logic                         out_x_wxd_o,
  output logic [XLEN-1:0]              out_x_wb_wxd_rd_o,
  output logic                         out_v_valid_o,
  input  logic                         out_v_ready_i,
  output logic [DEPTH_WARP-1:0]        out_v_warp_id_o,
  output logic [REG_W-1:0]             out_v_reg_idxw_o,
  output logic [NUM_THREAD-1:0]        out_v_wvd_mask_o,
  output logic [XLEN*NUM_THREAD-1:0]   out_v_wb_wvd_rd_o,
  output logic                         out_v_wvd_o,
  output logic                         idle_o
);

  localparam int XAW = $clog2(X_DEPTH);
  localparam int VAW = $clog2(V_DEPTH);
  localparam int VW  = XLEN * NUM_THREAD;
  localparam logic [XAW:0] X_ONE = 1;
  localparam logic [VAW:0] V_ONE = 1;

  logic [DEPTH_WARP-1:0] x_warp_mem [X_DEPTH];
  logic [REG_W-1:0]      x_reg_mem  [X_DEPTH];
  logic [XLEN-1:0]       x_data_mem [X_DEPTH];

  logic [DEPTH_WARP-1:0] v_warp_mem [V_DEPTH];
  logic [REG_W-1:0]      v_reg_mem  [V_DEPTH];
  logic [NUM_THREAD-1:0] v_mask_mem [V_DEPTH];
  logic [VW-1:0]         v_data_mem [V_DEPTH];

  logic [XAW:0] x_wr_q, x_wr_d, x_rd_q, x_rd_d;
  logic [VAW:0] v_wr_q, v_wr_d, v_rd_q, v_rd_d;

  logic x_empty, x_full, v_empty, v_full;
  logic accept, x_push, v_push, x_pop, v_pop;

  assign x_empty = (x_wr_q == x_rd_q);
  assign x_full  = (x_wr_q[XAW] != x_rd_q[XAW]) && (x_wr_q[XAW-1:0] == x_rd_q[XAW-1:0]);
  assign v_empty = (v_wr_q == v_rd_q);
  assign v_full  = (v_wr_q[VAW] != v_rd_q[VAW]) && (v_wr_q[VAW-1:0] == v_rd_q[VAW-1:0]);

  // Ready looks only at full flags so writeback stalls never reach the LSU combinationally.
  assign lsu_rsp_ready_o = !(lsu_rsp_wxd_i && x_full) && !(lsu_rsp_wfd_i && v_full);

  assign accept = lsu_rsp_valid_i && lsu_rsp_ready_o;
  assign x_push = accept && lsu_rsp_wxd_i;
  assign v_push = accept && lsu_rsp_wfd_i;
  assign x_pop  = !x_empty && out_x_ready_i;
  assign v_pop  = !v_empty && out_v_ready_i;

  always_comb begin
    x_wr_d = x_push ? x_wr_q + X_ONE : x_wr_q;
    x_rd_d = x_pop  ? x_rd_q + X_ONE : x_rd_q;
    v_wr_d = v_push ? v_wr_q + V_ONE : v_wr_q;
    v_rd_d = v_pop  ? v_rd_q + V_ONE : v_rd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_wr_q <= '0;
      x_rd_q <= '0;
      v_wr_q <= '0;
      v_rd_q <= '0;
    end else begin
      x_wr_q <= x_wr_d;
      x_rd_q <= x_rd_d;
      v_wr_q <= v_wr_d;
      v_rd_q <= v_rd_d;
    end
  end

  // Entry storage carries no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (x_push) begin
      x_warp_mem[x_wr_q[XAW-1:0]] <= lsu_rsp_warp_id_i;
      x_reg_mem[x_wr_q[XAW-1:0]]  <= lsu_rsp_reg_idxw_i;
      x_data_mem[x_wr_q[XAW-1:0]] <= lsu_rsp_data_i[XLEN-1:0];
    end
    if (v_push) begin
      v_warp_mem[v_wr_q[VAW-1:0]] <= lsu_rsp_warp_id_i;
      v_reg_mem[v_wr_q[VAW-1:0]]  <= lsu_rsp_reg_idxw_i;
      v_mask_mem[v_wr_q[VAW-1:0]] <= lsu_rsp_mask_i;
      v_data_mem[v_wr_q[VAW-1:0]] <= lsu_rsp_data_i;
    end
  end

  assign out_x_valid_o     = !x_empty;
  assign out_x_wxd_o       = !x_empty;
  assign out_x_warp_id_o   = x_warp_mem[x_rd_q[XAW-1:0]];
  assign out_x_reg_idxw_o  = x_reg_mem[x_rd_q[XAW-1:0]];
  assign out_x_wb_wxd_rd_o = x_data_mem[x_rd_q[XAW-1:0]];

  assign out_v_valid_o     = !v_empty;
  assign out_v_wvd_o       = !v_empty;
  assign out_v_warp_id_o   = v_warp_mem[v_rd_q[VAW-1:0]];
  assign out_v_reg_idxw_o  = v_reg_mem[v_rd_q[VAW-1:0]];
  assign out_v_wvd_mask_o  = v_mask_mem[v_rd_q[VAW-1:0]];
  assign out_v_wb_wvd_rd_o = v_data_mem[v_rd_q[VAW-1:0]];

  assign idle_o = x_empty && v_empty;

endmodule
